cam_rx_monitor: RTL and testbench

// - Receive end of the parallel camera interface (pclk/vsync/href/8-bit data, RGB565, two bytes per pixel).
// - Samples the bus driven by the camera VIP and rebuilds 16-bit pixels with column/line coordinates.
// - Checks frame geometry and reports per-frame status to the testbench scoreboard.
// - Sits in the TB next to the camera VIP, in parallel with the DUT camera input pins.

---
 rtl/cam_rx_monitor.sv | 133 +++++++++++++
 tb/tb_cam_rx_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cam_rx_monitor.sv
// cam_rx_monitor: camera bus receive monitor rebuilding RGB565 pixels and checking frame geometry.
// Optional CRC-16-CCITT over emitted pixel bytes is enabled by defining CAM_RX_CRC_EN.
module cam_rx_monitor #(
  parameter int HRES = 640,
  parameter int VRES = 480
) (
  input  logic        cam_pclk_o,
  input  logic        s_rstn,
  input  logic        en_i,
  input  logic        cam_vsync_i,
  input  logic        cam_href_i,
  input  logic [7:0]  cam_data_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_data_o,
  output logic [15:0] pix_col_o,
  output logic [15:0] pix_line_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o,
  output logic        err_line_len_o,
  output logic        err_line_cnt_o,
  output logic        err_odd_byte_o
`ifdef CAM_RX_CRC_EN
  ,
  output logic [15:0] frame_crc_o
`endif
);
  typedef enum logic [1:0] {IDLE, VSYNC, ACTIVE, CLOSE} state_t;
  localparam logic [15:0] H = 16'(HRES);
  localparam logic [15:0] V = 16'(VRES);
  state_t r_state, w_next;
  logic r_vs, r_vs_d, r_hr, r_hr_d, r_phase;
  logic [7:0] r_data, r_hi;
  logic [15:0] r_col, r_line, r_pix_data, r_pix_col, r_pix_line, r_frame_cnt;
  logic r_pix_valid, r_frame_done, r_err_len, r_err_cnt, r_err_odd;
  logic w_vs_rise, w_vs_fall, w_line_end, w_byte, w_emit, w_start;

  // A vsync rise with href still high closes the open line before the frame closes.
  always_comb begin
    w_vs_rise  = r_vs && !r_vs_d;
    w_vs_fall  = !r_vs && r_vs_d;
    w_line_end = r_state == ACTIVE && ((r_hr_d && !r_hr) || (w_vs_rise && r_hr));
    w_byte     = r_state == ACTIVE && r_hr && !w_vs_rise;
    w_emit     = en_i && w_byte && r_phase && r_col < H && r_line < V;
    w_start    = (r_state == IDLE && w_vs_rise) || r_state == CLOSE;
    w_next     = !en_i              ? IDLE :
                 r_state == IDLE    ? (w_vs_rise ? VSYNC : IDLE) :
                 r_state == VSYNC   ? (w_vs_fall ? ACTIVE : VSYNC) :
                 r_state == ACTIVE  ? (w_vs_rise ? CLOSE : ACTIVE) : VSYNC;
  end

  always_ff @(posedge cam_pclk_o or negedge s_rstn)
    if (!s_rstn) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge cam_pclk_o or negedge s_rstn) begin
    if (!s_rstn) begin
      {r_vs, r_vs_d, r_hr, r_hr_d, r_phase, r_data, r_hi} <= '0;
      {r_col, r_line, r_pix_data, r_pix_col, r_pix_line, r_frame_cnt} <= '0;
      {r_pix_valid, r_frame_done, r_err_len, r_err_cnt, r_err_odd} <= '0;
    end else begin
      r_vs         <= cam_vsync_i;
      r_vs_d       <= r_vs;
      r_hr         <= cam_href_i;
      r_hr_d       <= r_hr;
      r_data       <= cam_data_i;
      r_pix_valid  <= w_emit;
      r_frame_done <= en_i && r_state == CLOSE;
      if (en_i) begin
        if (w_emit) begin
          r_pix_data <= {r_hi, r_data};
          r_pix_col  <= r_col;
          r_pix_line <= r_line;
        end
        // Errors stay visible alongside frame_done_o, then clear for the new frame.
        if (r_frame_done || (r_state == IDLE && w_vs_rise)) {r_err_len, r_err_cnt, r_err_odd} <= '0;
        if (r_state == CLOSE) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_err_cnt   <= r_line != V;
        end
        if (w_start) r_line <= '0;
        if (r_state != ACTIVE) begin
          r_col   <= '0;
          r_phase <= 1'b0;
        end else if (w_line_end) begin
          if (r_col != H) r_err_len <= 1'b1;
          if (r_phase) r_err_odd <= 1'b1;
          r_col   <= '0;
          r_phase <= 1'b0;
          r_line  <= r_line == 16'hFFFF ? r_line : r_line + 16'd1;
        end else if (w_byte) begin
          r_phase <= !r_phase;
          if (!r_phase) r_hi <= r_data;
          else if (r_col == H) r_err_len <= 1'b1;
          else r_col <= r_col + 16'd1;
        end
      end
    end
  end

  assign pix_valid_o    = r_pix_valid;
  assign pix_data_o     = r_pix_data;
  assign pix_col_o      = r_pix_col;
  assign pix_line_o     = r_pix_line;
  assign frame_done_o   = r_frame_done;
  assign frame_cnt_o    = r_frame_cnt;
  assign err_line_len_o = r_err_len;
  assign err_line_cnt_o = r_err_cnt;
  assign err_odd_byte_o = r_err_odd;

`ifdef CAM_RX_CRC_EN
  logic [15:0] r_crc, r_frame_crc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) x = x[15] ? ({x[14:0], 1'b0} ^ 16'h1021) : {x[14:0], 1'b0};
    return x;
  endfunction

  always_ff @(posedge cam_pclk_o or negedge s_rstn) begin
    if (!s_rstn) begin
      r_crc       <= 16'hFFFF;
      r_frame_crc <= '0;
    end else if (en_i) begin
      if (r_state == CLOSE) r_frame_crc <= r_crc;
      if (w_start) r_crc <= 16'hFFFF;
      else if (w_emit) r_crc <= crc_byte(crc_byte(r_crc, r_hi), r_data);
    end
  end

  assign frame_crc_o = r_frame_crc;
`endif
endmodule

// File: tb/tb_cam_rx_monitor.sv
// tb_cam_rx_monitor: random-data frames against a line/pixel-level scoreboard of cam_rx_monitor.
// Small geometry keeps runs short; CAM_RX_CRC_EN also checks the frame CRC.
module tb_cam_rx_monitor;
  localparam int H = 8;
  localparam int V = 4;
  logic cam_pclk_o = 0, s_rstn = 0, en_i = 0, cam_vsync_i = 0, cam_href_i = 0;
  logic [7:0] cam_data_i = 0;
  logic pix_valid_o, frame_done_o, err_line_len_o, err_line_cnt_o, err_odd_byte_o;
  logic [15:0] pix_data_o, pix_col_o, pix_line_o, frame_cnt_o;
  int errors = 0, checks = 0, cyc = 0, done_seen = 0, fc = 0;
  logic [2:0] cap_err = 0;
  logic [15:0] cap_cnt = 0;
  logic e_len = 0, e_odd = 0, e_cnt = 0, pack = 0;
  logic [63:0] exp_q[$];
`ifdef CAM_RX_CRC_EN
  logic [15:0] frame_crc_o, crc_m = 16'hFFFF;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
`endif

  always #5 cam_pclk_o = ~cam_pclk_o;

  cam_rx_monitor #(.HRES(H), .VRES(V)) dut (
    .cam_pclk_o(cam_pclk_o), .s_rstn(s_rstn), .en_i(en_i),
    .cam_vsync_i(cam_vsync_i), .cam_href_i(cam_href_i), .cam_data_i(cam_data_i),
    .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o), .pix_col_o(pix_col_o),
    .pix_line_o(pix_line_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
    .err_line_len_o(err_line_len_o), .err_line_cnt_o(err_line_cnt_o),
    .err_odd_byte_o(err_odd_byte_o)
`ifdef CAM_RX_CRC_EN
    , .frame_crc_o(frame_crc_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One pclk: sample outputs on the falling edge, then drive the next bus value.
  task automatic tick(input logic v, input logic h, input logic [7:0] b);
    @(negedge cam_pclk_o);
    cyc++;
    if (pix_valid_o)
      chk("pix", {pix_data_o, pix_col_o, pix_line_o, 16'(cyc)}, exp_q.size() > 0 ? exp_q.pop_front() : '1);
    if (frame_done_o) begin
      done_seen++;
      cap_err = {err_line_len_o, err_line_cnt_o, err_odd_byte_o};
      cap_cnt = frame_cnt_o;
    end
    cam_vsync_i = v;
    cam_href_i  = h;
    cam_data_i  = b;
  endtask

  task automatic pulse();
    repeat (3) tick(1, 0, 8'h00);
    repeat (2) tick(0, 0, 8'h00);
  endtask

  // Pixel appears two sampling ticks after its second byte is driven.
  task automatic line(input int ln, input int nb);
    logic [7:0] hi, b;
    int px;
    hi = 0;
    px = 0;
    for (int i = 0; i < nb; i++) begin
      b = (pack && ln == 0 && i < 2) ? (i == 0 ? 8'hF8 : 8'h1F) : 8'($urandom);
      tick(0, 1, b);
      if (i % 2 == 0) hi = b;
      else begin
        if (px < H && ln < V) begin
          exp_q.push_back({hi, b, 16'(px), 16'(ln), 16'(cyc + 2)});
`ifdef CAM_RX_CRC_EN
          crc_m = crc_upd(crc_upd(crc_m, hi), b);
`endif
        end
        px++;
      end
    end
    repeat (3) tick(0, 0, 8'h00);
    e_len |= (nb / 2 != H);
    e_odd |= (nb % 2 != 0);
    chk("live_err", {62'd0, err_line_len_o, err_odd_byte_o}, {62'd0, e_len, e_odd});
  endtask

  task automatic frame(input int nl, input int bad_ln, input int bad_nb);
    e_len = 0;
    e_odd = 0;
`ifdef CAM_RX_CRC_EN
    crc_m = 16'hFFFF;
`endif
    for (int l = 0; l < nl; l++) line(l, l == bad_ln ? bad_nb : 2 * H);
    e_cnt = (nl != V);
  endtask

  task automatic close(input string tag);
    int d0;
    d0 = done_seen;
    pulse();
    fc++;
    chk({tag, "_done"}, done_seen, d0 + 1);
    chk({tag, "_err"}, cap_err, {e_len, e_cnt, e_odd});
    chk({tag, "_cnt"}, cap_cnt, fc);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_clr"}, {err_line_len_o, err_line_cnt_o, err_odd_byte_o}, 0);
`ifdef CAM_RX_CRC_EN
    chk({tag, "_crc"}, frame_crc_o, crc_m);
`endif
  endtask

  initial begin
    int d0, nl, bl, bn;
    repeat (3) @(negedge cam_pclk_o);
    chk("rst_pix", {pix_valid_o, pix_data_o, pix_col_o, pix_line_o}, 0);
    chk("rst_frm", {frame_done_o, frame_cnt_o, err_line_len_o, err_line_cnt_o, err_odd_byte_o}, 0);
`ifdef CAM_RX_CRC_EN
    chk("rst_crc", frame_crc_o, 0);
`endif
    s_rstn = 1;
    en_i = 1;
    pulse();
    chk("idle_start_no_done", done_seen, 0);
    pack = 1;
    frame(V, -1, 0);
    close("nom0");
    pack = 0;
    frame(V, -1, 0);
    close("nom1");
    frame(V, 1, 2 * H - 2);
    close("short");
    frame(V, -1, 0);
    close("after_short");
    frame(V, 0, 2 * H + 1);
    close("odd");
    frame(V - 1, -1, 0);
    close("few_lines");
    frame(V + 1, -1, 0);
    close("many_lines");
    frame(V, 2, 2 * H + 4);
    close("overflow");
    for (int k = 0; k < 4; k++) begin
      nl = $urandom_range(V + 1, V - 1);
      bl = $urandom_range(V - 1, 0);
      bn = $urandom_range(2 * H + 3, 2 * H - 3);
      frame(nl, bl, bn);
      close("rand");
    end
    e_len = 0;
    e_odd = 0;
    line(0, 2 * H);
    line(1, 2 * H);
    d0 = done_seen;
    en_i = 0;
    repeat (4) tick(0, 0, 8'h00);
    pulse();
    chk("abort_no_done", done_seen, d0);
    chk("abort_cnt", frame_cnt_o, fc);
    en_i = 1;
    pulse();
    chk("reenable_no_done", done_seen, d0);
    frame(V, -1, 0);
    close("abort_next");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
